// File: rtl/pipe_pkg.sv
// Shared pipeline types and helpers for the MIPS core.
// Used by the MEM/WB stage and its data memory.
package pipe_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   typedef struct packed {
      logic RegWrite;
      logic Mem2Reg;
   } memwb_ctrl_t;

   function automatic logic is_misaligned(input logic [1:0] addr);
      return addr != 2'b00;
   endfunction

endpackage

// File: rtl/dmem_sp.sv
// Single-port synchronous data RAM, word addressed.
// A read that coincides with a write returns the old contents.
module dmem_sp
   import pipe_pkg::*;
#(
   parameter int DEPTH_WORDS = 128,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
   end

   // rdata only moves on an enabled read, so it survives stalls
   always_ff @(posedge clk) begin
      if (re)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory access plus the MEM/WB pipeline register.
// Stall holds everything, flush inserts a bubble, reset clears outputs.
module mem_wb_stage
   import pipe_pkg::*;
#(
   parameter int DEPTH_WORDS = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RegWrite_in,
   input  logic                  Mem2Reg_in,
   input  logic                  MemRead_in,
   input  logic                  MemWrite_in,
   input  logic [DATA_W-1:0]     ALU_result_in,
   input  logic [DATA_W-1:0]     RtData_in,
   input  logic [REG_ADDR_W-1:0] RdAddr_in,
   input  logic                  stall,
   input  logic                  flush,
   output logic                  RegWrite_out,
   output logic                  Mem2Reg_out,
   output logic [DATA_W-1:0]     MemData_out,
   output logic [DATA_W-1:0]     ALU_result_out,
   output logic [REG_ADDR_W-1:0] RdAddr_out,
   output logic                  misalign_err
);

   localparam int ADDR_W = $clog2(DEPTH_WORDS);

   logic              advance;
   logic              misalign;
   logic              ramWe;
   logic              ramRe;
   logic [ADDR_W-1:0] wordIdx;
   logic [DATA_W-1:0] ramData;
   logic              loadValid;
   memwb_ctrl_t       ctrlQ;

   assign advance  = rst_n & ~flush & ~stall;
   assign misalign = (MemRead_in | MemWrite_in) &
                     is_misaligned(ALU_result_in[1:0]);
   assign wordIdx  = ALU_result_in[ADDR_W+1:2];
   assign ramWe    = advance & MemWrite_in & ~misalign;
   assign ramRe    = advance & MemRead_in & ~misalign;

   dmem_sp #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) uDmem (
      .clk   (clk),
      .we    (ramWe),
      .re    (ramRe),
      .addr  (wordIdx),
      .wdata (RtData_in),
      .rdata (ramData)
   );

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         ctrlQ          <= '0;
         loadValid      <= 1'b0;
         ALU_result_out <= '0;
         RdAddr_out     <= '0;
         misalign_err   <= 1'b0;
      end else if (!stall) begin
         ctrlQ.RegWrite <= RegWrite_in & ~misalign;
         ctrlQ.Mem2Reg  <= Mem2Reg_in;
         loadValid      <= MemRead_in & ~misalign;
         ALU_result_out <= ALU_result_in;
         RdAddr_out     <= RdAddr_in;
         misalign_err   <= misalign;
      end
   end

   // Load data is the RAM's registered word, zeroed when no load was taken
   assign MemData_out  = loadValid ? ramData : '0;
   assign RegWrite_out = ctrlQ.RegWrite;
   assign Mem2Reg_out  = ctrlQ.Mem2Reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage against a behavioural model.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RegWrite_in, Mem2Reg_in, MemRead_in, MemWrite_in;
   logic [31:0] ALU_result_in, RtData_in;
   logic [4:0]  RdAddr_in;
   logic        stall, flush;
   logic        RegWrite_out, Mem2Reg_out, misalign_err;
   logic [31:0] MemData_out, ALU_result_out;
   logic [4:0]  RdAddr_out;

   int nChecks = 0;
   int nFails  = 0;

   logic [31:0] mdl [128];
   logic        eRw, eM2r, eErr;
   logic [31:0] eData, eAlu;
   logic [4:0]  eRd;

   always #5 clk = ~clk;

   mem_wb_stage #(.DEPTH_WORDS(128)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .RegWrite_in    (RegWrite_in),
      .Mem2Reg_in     (Mem2Reg_in),
      .MemRead_in     (MemRead_in),
      .MemWrite_in    (MemWrite_in),
      .ALU_result_in  (ALU_result_in),
      .RtData_in      (RtData_in),
      .RdAddr_in      (RdAddr_in),
      .stall          (stall),
      .flush          (flush),
      .RegWrite_out   (RegWrite_out),
      .Mem2Reg_out    (Mem2Reg_out),
      .MemData_out    (MemData_out),
      .ALU_result_out (ALU_result_out),
      .RdAddr_out     (RdAddr_out),
      .misalign_err   (misalign_err)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: apply the stage rules to the inputs seen at this edge
   task automatic modelStep();
      bit          mis;
      int          idx;
      logic [31:0] old;
      if (!rst_n || flush) begin
         {eRw, eM2r, eErr} = '0;
         eData = 0; eAlu = 0; eRd = 0;
      end else if (!stall) begin
         mis = (MemRead_in || MemWrite_in) && (ALU_result_in % 4 != 0);
         idx = int'((ALU_result_in / 4) % 128);
         old = mdl[idx];
         eRw   = RegWrite_in && !mis;
         eM2r  = Mem2Reg_in;
         eData = (MemRead_in && !mis) ? old : 32'h0;
         eAlu  = ALU_result_in;
         eRd   = RdAddr_in;
         eErr  = mis;
         if (MemWrite_in && !mis)
            mdl[idx] = RtData_in;
      end
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      #1;
      modelStep();
      chk({tag, ".rw"},   32'(RegWrite_out),   32'(eRw));
      chk({tag, ".m2r"},  32'(Mem2Reg_out),    32'(eM2r));
      chk({tag, ".data"}, MemData_out,         eData);
      chk({tag, ".alu"},  ALU_result_out,      eAlu);
      chk({tag, ".rd"},   32'(RdAddr_out),     32'(eRd));
      chk({tag, ".err"},  32'(misalign_err),   32'(eErr));
   endtask

   task automatic drive(input logic rw, input logic m2r, input logic rd_,
                        input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rdA);
      RegWrite_in = rw; Mem2Reg_in = m2r; MemRead_in = rd_;
      MemWrite_in = wr; ALU_result_in = a; RtData_in = d;
      RdAddr_in = rdA;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      {eRw, eM2r, eErr} = '0;
      eData = 0; eAlu = 0; eRd = 0;
      for (int i = 0; i < 128; i++) mdl[i] = 32'h0;

      drive(1, 1, 1, 0, 32'h40, 32'h1, 5'd9);
      cyc("reset0");
      cyc("reset1");
      chk("reset_rw", 32'(RegWrite_out), 32'h0);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      cyc("idle");

      // known memory contents
      for (int i = 0; i < 128; i++) begin
         drive(0, 0, 0, 1, 32'(i * 4), 32'h0, 5'd0);
         cyc("init");
      end

      drive(0, 0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd3);
      cyc("st10");
      drive(1, 1, 1, 0, 32'h10, 32'h0, 5'd7);
      cyc("ld10");
      chk("ld10_data", MemData_out, 32'hDEADBEEF);
      chk("ld10_m2r", 32'(Mem2Reg_out), 32'h1);
      chk("ld10_rw", 32'(RegWrite_out), 32'h1);
      chk("ld10_rd", 32'(RdAddr_out), 32'd7);

      drive(0, 0, 0, 1, 32'h204, 32'h12345678, 5'd0);
      cyc("st204");
      drive(1, 1, 1, 0, 32'h004, 32'h0, 5'd4);
      cyc("ld004");
      chk("alias_data", MemData_out, 32'h12345678);

      drive(1, 1, 1, 0, 32'h13, 32'h0, 5'd5);
      cyc("mis13");
      chk("mis_err", 32'(misalign_err), 32'h1);
      chk("mis_rw", 32'(RegWrite_out), 32'h0);
      chk("mis_data", MemData_out, 32'h0);
      drive(0, 0, 0, 1, 32'h11, 32'hFFFFFFFF, 5'd0);
      cyc("mis11");
      chk("mis_err2", 32'(misalign_err), 32'h1);
      drive(1, 1, 1, 0, 32'h10, 32'h0, 5'd6);
      cyc("ld10b");
      chk("mis_oneshot", 32'(misalign_err), 32'h0);
      chk("mis_nostore", MemData_out, 32'hDEADBEEF);

      stall = 1'b1;
      drive(1, 0, 0, 1, 32'h20, 32'hA5A5A5A5, 5'd8);
      for (int i = 0; i < 3; i++) cyc("stall");
      chk("stall_hold", MemData_out, 32'hDEADBEEF);
      chk("stall_rd", 32'(RdAddr_out), 32'd6);
      stall = 1'b0;
      drive(1, 1, 1, 0, 32'h20, 32'h0, 5'd2);
      cyc("ld20");
      chk("stall_nostore", MemData_out, 32'h0);
      drive(0, 0, 0, 1, 32'h20, 32'hA5A5A5A5, 5'd0);
      cyc("st20");
      drive(1, 1, 1, 0, 32'h20, 32'h0, 5'd2);
      cyc("ld20b");
      chk("st20_commit", MemData_out, 32'hA5A5A5A5);

      flush = 1'b1; stall = 1'b1;
      drive(1, 1, 0, 1, 32'h24, 32'h55555555, 5'd1);
      cyc("flush");
      chk("flush_rw", 32'(RegWrite_out), 32'h0);
      chk("flush_alu", ALU_result_out, 32'h0);
      flush = 1'b0; stall = 1'b0;
      drive(1, 1, 1, 0, 32'h24, 32'h0, 5'd1);
      cyc("ld24");
      chk("flush_nostore", MemData_out, 32'h0);

      rst_n = 1'b0;
      drive(1, 1, 0, 1, 32'h28, 32'h66666666, 5'd1);
      cyc("rstmid");
      chk("rstmid_alu", ALU_result_out, 32'h0);
      rst_n = 1'b1;
      drive(1, 1, 1, 0, 32'h28, 32'h0, 5'd1);
      cyc("ld28");
      chk("rst_nostore", MemData_out, 32'h0);

      for (int n = 0; n < 1500; n++) begin
         logic [31:0] a;
         a = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'h0,
              4'($urandom), 4'($urandom), 2'b00};
         if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom);
         rst_n = ($urandom_range(0, 40) != 0);
         flush = ($urandom_range(0, 15) == 0);
         stall = ($urandom_range(0, 7) == 0);
         drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               a, $urandom, 5'($urandom));
         cyc("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

endmodule
